reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Sequences STAGES active-low reset outputs: all stages are held low for at
//   least HOLD cycles, then released one at a time in ascending order, spaced
//   STAGE_DELAY cycles apart. The sequence restarts on watchdog or software
//   requests. Repeated watchdog resets latch a FAIL state that can only be left
//   through the boot0 strap or rst_n.
//
// Ports
//   clk          system clock, all logic on its rising edge
//   rst_n        synchronous active-low reset
//   wdt_rst_n    watchdog request, active-low; its falling edge is a request
//   boot0        programming strap, asynchronous, active-high (synchronized here)
//   sw_req       single-cycle software reset request
//   cnt_clr      single-cycle pulse that clears rst_cnt
//   stage_rst_n  per-stage active-low resets
//   busy         high while any stage is still held in reset
//   cause        last reset cause: 0 rst_n, 1 watchdog, 2 software, 3 boot
//   rst_cnt      saturating count of watchdog-caused resets
//   fail         high while in the FAIL state
module reset_sequencer #(
  parameter int unsigned STAGES      = 4,
  parameter int unsigned HOLD        = 16,
  parameter int unsigned STAGE_DELAY = 1000,
  parameter int unsigned MAX_RETRY   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wdt_rst_n,
  input  logic              boot0,
  input  logic              sw_req,
  input  logic              cnt_clr,
  output logic [STAGES-1:0] stage_rst_n,
  output logic              busy,
  output logic [1:0]        cause,
  output logic [7:0]        rst_cnt,
  output logic              fail
);

  localparam int unsigned IDX_W = $clog2(STAGES + 1);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_IDLE,
    ST_BOOT,
    ST_FAIL
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t             state_q, state_d;
  logic               boot0_p0, boot0_p1;
  logic               wdt_prev;
  logic [15:0]        hold_q, hold_d;
  logic [31:0]        dly_q, dly_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [STAGES-1:0]  stage_d;
  logic               busy_d;
  logic [1:0]         cause_d;
  logic [7:0]         cnt_d;
  logic               fail_d;
  logic               wdt_req;
  logic               active;

  // Stage 0/1: boot0 synchronizer and registered state/outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      boot0_p0    <= 1'b0;
      boot0_p1    <= 1'b0;
      wdt_prev    <= 1'b1;
      state_q     <= ST_ASSERT;
      hold_q      <= '0;
      dly_q       <= '0;
      idx_q       <= '0;
      stage_rst_n <= '0;
      busy        <= 1'b1;
      cause       <= 2'd0;
      rst_cnt     <= 8'd0;
      fail        <= 1'b0;
    end else begin
      boot0_p0    <= boot0;
      boot0_p1    <= boot0_p0;
      wdt_prev    <= wdt_rst_n;
      state_q     <= state_d;
      hold_q      <= hold_d;
      dly_q       <= dly_d;
      idx_q       <= idx_d;
      stage_rst_n <= stage_d;
      busy        <= busy_d;
      cause       <= cause_d;
      rst_cnt     <= cnt_d;
      fail        <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dly_d   = dly_q;
    idx_d   = idx_q;
    stage_d = stage_rst_n;
    cause_d = cause;
    cnt_d   = cnt_clr ? 8'd0 : rst_cnt;

    wdt_req = wdt_prev & ~wdt_rst_n;
    // Requests only restart the sequence from the sequencing states.
    active  = (state_q == ST_ASSERT) || (state_q == ST_RELEASE) ||
              (state_q == ST_IDLE);

    if (boot0_p1) begin
      state_d = ST_BOOT;
      stage_d = '0;
      cause_d = 2'd3;
      cnt_d   = 8'd0;
      hold_d  = '0;
      dly_d   = '0;
      idx_d   = '0;
    end else if (active && wdt_req) begin
      // A same-cycle cnt_clr is applied first, so the increment wins.
      cnt_d   = sat_inc8(cnt_clr ? 8'd0 : rst_cnt);
      cause_d = 2'd1;
      stage_d = '0;
      hold_d  = '0;
      dly_d   = '0;
      idx_d   = '0;
      state_d = ({24'd0, cnt_d} >= MAX_RETRY) ? ST_FAIL : ST_ASSERT;
    end else if (active && sw_req) begin
      cause_d = 2'd2;
      stage_d = '0;
      hold_d  = '0;
      dly_d   = '0;
      idx_d   = '0;
      state_d = ST_ASSERT;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          stage_d = '0;
          // Counter parks at HOLD-1 while the watchdog line is still low.
          if (hold_q == 16'(HOLD - 1)) begin
            if (wdt_rst_n) begin
              state_d = ST_RELEASE;
              dly_d   = '0;
              idx_d   = '0;
            end
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
        ST_RELEASE: begin
          if (dly_q == 32'(STAGE_DELAY - 1)) begin
            dly_d = '0;
            for (int i = 0; i < int'(STAGES); i++) begin
              if (int'(idx_q) == i) stage_d[i] = 1'b1;
            end
            idx_d = idx_q + 1'b1;
            if (int'(idx_q) == int'(STAGES) - 1) state_d = ST_IDLE;
          end else begin
            dly_d = dly_q + 32'd1;
          end
        end
        ST_IDLE: begin
        end
        ST_BOOT: begin
          state_d = ST_ASSERT;
          stage_d = '0;
          hold_d  = '0;
        end
        ST_FAIL: begin
          stage_d = '0;
        end
        default: begin
          state_d = ST_ASSERT;
          stage_d = '0;
          hold_d  = '0;
        end
      endcase
    end

    busy_d = ~(&stage_d);
    fail_d = (state_d == ST_FAIL);
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int STAGES      = 4;
  localparam int HOLD        = 16;
  localparam int STAGE_DELAY = 8;
  localparam int MAX_RETRY   = 3;

  localparam int M_SEQ  = 0;
  localparam int M_BOOT = 1;
  localparam int M_FAIL = 2;

  logic              clk;
  logic              rst_n;
  logic              wdt_rst_n;
  logic              boot0;
  logic              sw_req;
  logic              cnt_clr;
  logic [STAGES-1:0] stage_rst_n;
  logic              busy;
  logic [1:0]        cause;
  logic [7:0]        rst_cnt;
  logic              fail;

  reset_sequencer #(
    .STAGES(STAGES),
    .HOLD(HOLD),
    .STAGE_DELAY(STAGE_DELAY),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wdt_rst_n(wdt_rst_n),
    .boot0(boot0),
    .sw_req(sw_req),
    .cnt_clr(cnt_clr),
    .stage_rst_n(stage_rst_n),
    .busy(busy),
    .cause(cause),
    .rst_cnt(rst_cnt),
    .fail(fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {stages[3:0], busy, cause[1:0], rst_cnt[7:0], fail}
  logic [15:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int mon_cyc = 0;

  // Reference model: time-stamp based. Stage k of a sequence is up once
  // (k+1)*STAGE_DELAY edges have passed since the hold period ended.
  int n = 0;
  int mode = M_SEQ;
  int t_assert = 0;
  int rel_start = -1;
  int m_cause = 0;
  int m_cnt = 0;
  bit m_prev_wdt = 1'b1;
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;

  task automatic model_edge();
    bit bs;
    bit wreq;
    logic [STAGES-1:0] st;
    logic [15:0] w;
    n++;
    if (!rst_n) begin
      mode = M_SEQ; t_assert = n; rel_start = -1;
      m_cause = 0; m_cnt = 0; m_prev_wdt = 1'b1; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      bs = m_s2; m_s2 = m_s1; m_s1 = boot0;
      wreq = m_prev_wdt && !wdt_rst_n;
      m_prev_wdt = wdt_rst_n;
      if (cnt_clr) m_cnt = 0;
      if (bs) begin
        mode = M_BOOT; m_cause = 3; m_cnt = 0;
      end else if (mode == M_SEQ && wreq) begin
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        m_cause = 1;
        if (m_cnt >= MAX_RETRY) mode = M_FAIL;
        else begin t_assert = n; rel_start = -1; end
      end else if (mode == M_SEQ && sw_req) begin
        m_cause = 2; t_assert = n; rel_start = -1;
      end else if (mode == M_BOOT) begin
        mode = M_SEQ; t_assert = n; rel_start = -1;
      end else if (mode == M_SEQ && rel_start < 0 && (n - t_assert) >= HOLD && wdt_rst_n) begin
        rel_start = n;
      end
    end
    st = '0;
    if (mode == M_SEQ && rel_start >= 0)
      for (int k = 0; k < STAGES; k++) st[k] = ((n - rel_start) >= (k + 1) * STAGE_DELAY);
    w = {st, (st != {STAGES{1'b1}}), 2'(m_cause), 8'(m_cnt), (mode == M_FAIL)};
    exp_q.push_back(w);
  endtask

  task automatic step(input logic r, input logic w, input logic b, input logic s, input logic c);
    rst_n = r; wdt_rst_n = w; boot0 = b; sw_req = s; cnt_clr = c;
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles, input logic w);
    for (int i = 0; i < cycles; i++) step(1'b1, w, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, so one expectation per edge.
  initial begin
    logic [15:0] e;
    logic [15:0] got;
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      checks++;
      got = {stage_rst_n, busy, cause, rst_cnt, fail};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow cyc=%0d got=%h required an expectation", mon_cyc, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          if (errors <= 30)
            $display("FAIL outputs cyc=%0d got stage=%b busy=%b cause=%0d cnt=%0d fail=%b required stage=%b busy=%b cause=%0d cnt=%0d fail=%b",
                     mon_cyc, got[15:12], got[11], got[10:9], got[8:1], got[0],
                     e[15:12], e[11], e[10:9], e[8:1], e[0]);
        end
      end
    end
  end

  initial begin
    logic wl;
    int boot_left;
    rst_n = 1'b0; wdt_rst_n = 1'b1; boot0 = 1'b0; sw_req = 1'b0; cnt_clr = 1'b0;

    // Plain power-on sequence.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(60, 1'b1);

    // Software request with two stages already released.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(35, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(60, 1'b1);

    // Three watchdog edges, each after IDLE; the third one fails.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
      idle(60, 1'b1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(5, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b1);

    // boot0 escapes FAIL, then a normal sequence follows.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(60, 1'b1);

    // Watchdog line held low for 100 cycles.
    idle(100, 1'b0);
    idle(60, 1'b1);

    // cnt_clr together with a watchdog edge while rst_cnt = 1.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(60, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // rst_n mid-sequence.
    idle(30, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(60, 1'b1);

    // Randomized traffic.
    wl = 1'b1;
    boot_left = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, b, s, c;
      if ($urandom_range(0, 39) == 0) wl = ~wl;
      if (boot_left == 0 && $urandom_range(0, 299) == 0) boot_left = $urandom_range(1, 6);
      b = (boot_left != 0);
      if (boot_left != 0) boot_left--;
      r = ($urandom_range(0, 399) != 0);
      s = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 79) == 0);
      step(r, wl, b, s, c);
    end
    idle(2, 1'b1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
